// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its statistics counters.
package fetch_pkg;

    localparam int WORD_LEN = 32;
    localparam int STALL_W  = WORD_LEN;
    localparam int FLUSH_W  = 16;

    typedef logic [WORD_LEN-1:0] word_t;

    typedef enum logic {
        FETCH = 1'b0,
        BUF   = 1'b1
    } fetch_state_t;

    localparam word_t NOP_INSTR = '0;
    localparam word_t PC_STEP   = 32'd4;

    // Branch offsets are in words; the shift turns them into a byte displacement.
    function automatic word_t branch_target(input word_t base, input word_t word_offset);
        return base + (word_offset << 2);
    endfunction

endpackage

// File: rtl/fetch_stats.sv
// Saturating stall-cycle and flush counters for the fetch stage (built only with FETCH_STATS_EN).
module fetch_stats
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    output logic [STALL_W-1:0] stall_cycles,
    output logic [FLUSH_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-entry skid buffer, branch redirect and IF/ID register.
// Optional statistics counters are compiled in with the FETCH_STATS_EN macro.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
`endif
    output logic        if_valid
);

    fetch_state_t state;
    word_t        pc;
    word_t        pc_seq;
    word_t        skid;
    word_t        skid_pc;
    logic         branch;

    assign pc_seq    = pc + PC_STEP;
    assign branch    = br_taken && !freeze && if_valid;
    assign imem_addr = pc;
    // Gated by rst directly so the request drops in the very cycle reset is asserted.
    assign imem_req  = !rst && (state == FETCH);

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would let later statements observe half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            skid     <= '0;
            skid_pc  <= '0;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (branch) begin
            // Any ack this cycle and any parked word belong to the wrong path.
            state    <= FETCH;
            pc       <= branch_target(if_pc, br_offset);
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc_seq;
                        if (freeze) begin
                            skid    <= imem_rdata;
                            skid_pc <= pc_seq;
                            state   <= BUF;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc_seq;
                            if_valid <= 1'b1;
                        end
                    end
                end
                BUF: begin
                    if (!freeze) begin
                        if_instr <= skid;
                        if_pc    <= skid_pc;
                        if_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    fetch_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .stall        (imem_req && !imem_ack),
        .flush        (branch && !rst),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; stats checks are active when FETCH_STATS_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, br_taken, imem_ack;
    logic [31:0] br_offset, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;

    logic        w_rst, w_ack;
    logic [31:0] w_rdata;
    logic        w_req, w_if_valid;
    logic [31:0] w_addr, w_if_instr, w_if_pc;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_cycles, w_stall_cycles;
    logic [15:0] flush_count, w_flush_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
`ifdef FETCH_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .if_valid     (if_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (w_rst),
        .freeze       (1'b0),
        .br_taken     (1'b0),
        .br_offset    (32'h0),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ack     (w_ack),
        .imem_rdata   (w_rdata),
        .if_instr     (w_if_instr),
        .if_pc        (w_if_pc),
`ifdef FETCH_STATS_EN
        .stall_cycles (w_stall_cycles),
        .flush_count  (w_flush_count),
`endif
        .if_valid     (w_if_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        freeze = 0; br_taken = 0; br_offset = '0; imem_ack = 0; imem_rdata = '0;
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    // Acks one word at the current address with a zero-wait fetch.
    task automatic fetch_word(input logic [31:0] data);
        imem_ack = 1; imem_rdata = data;
        tick();
        imem_ack = 0; imem_rdata = '0;
    endtask

    task automatic test_reset();
        freeze = 0; br_taken = 1; br_offset = 32'd4;
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        rst = 1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_during_rst: got %b want 0", imem_req); end
        tick();
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_held: got %b want 0", imem_req); end
        rst = 0; br_taken = 0; imem_ack = 0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req_after: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
            fetch_word(32'h1000_0000 | 32'(i));
            checks++;
            if (if_instr !== (32'h1000_0000 | 32'(i))) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, if_instr, 32'h1000_0000 | 32'(i)); end
            checks++;
            if (if_pc !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_if_pc[%0d]: got %h want %h", i, if_pc, 32'(4 * i + 4)); end
            checks++;
            if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, if_valid); end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_instr;
        do_reset();
        exp_instr = 32'h0;
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (imem_addr !== 32'(4 * w)) begin errors++; $display("FAIL wait_addr[%0d.%0d]: got %h want %h", w, c, imem_addr, 32'(4 * w)); end
                imem_ack   = (c == 2);
                imem_rdata = (c == 2) ? (32'h2000_0000 | 32'(w)) : 32'hBAD0_0000;
                if (c == 2) exp_instr = 32'h2000_0000 | 32'(w);
                tick();
                checks++;
                if (if_instr !== exp_instr) begin errors++; $display("FAIL wait_instr[%0d.%0d]: got %h want %h", w, c, if_instr, exp_instr); end
            end
        end
        imem_ack = 0;
`ifdef FETCH_STATS_EN
        checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL wait_stall_cycles: got %0d want 4", stall_cycles); end
`endif
    endtask

    task automatic test_freeze();
        do_reset();
        fetch_word(32'h3000_0000);
        fetch_word(32'h3000_0004);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL frz_pre_addr: got %h want 00000008", imem_addr); end
        freeze = 1;
        fetch_word(32'hAAAA_0001);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL frz_req_buf: got %b want 0", imem_req); end
        checks++; if (if_instr !== 32'h3000_0004) begin errors++; $display("FAIL frz_instr_held: got %h want 30000004", if_instr); end
        checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL frz_if_pc_held: got %h want 00000008", if_pc); end
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL frz_addr_adv: got %h want 0000000c", imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL frz_buf_hold: got %b want 0", imem_req); end
        freeze = 0;
        tick();
        checks++; if (if_instr !== 32'hAAAA_0001) begin errors++; $display("FAIL frz_release_instr: got %h want aaaa0001", if_instr); end
        checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL frz_release_if_pc: got %h want 0000000c", if_pc); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL frz_release_valid: got %b want 1", if_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL frz_release_req: got %b want 1", imem_req); end
    endtask

    task automatic test_branch();
        do_reset();
        for (int k = 0; k < 8; k++) fetch_word(32'h4000_0000 | 32'(4 * k));
        checks++; if (if_pc !== 32'h20) begin errors++; $display("FAIL br_setup_if_pc: got %h want 00000020", if_pc); end
        br_taken = 1; br_offset = 32'hFFFF_FFFE;
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0;
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL br_target: got %h want 00000018", imem_addr); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL br_nop: got %h want 00000000", if_instr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", if_valid); end
`ifdef FETCH_STATS_EN
        checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL br_flush_count: got %0d want 1", flush_count); end
`endif
        // br_taken while if_valid=0 must be ignored.
        br_offset = 32'd100;
        tick();
        checks++; if (imem_addr !== 32'h18) begin errors++; $display("FAIL br_ignored_invalid: got %h want 00000018", imem_addr); end
        br_taken = 0;
        fetch_word(32'h5555_0018);
        checks++; if (if_instr !== 32'h5555_0018) begin errors++; $display("FAIL br_target_instr: got %h want 55550018", if_instr); end
        checks++; if (if_pc !== 32'h1C) begin errors++; $display("FAIL br_target_if_pc: got %h want 0000001c", if_pc); end
    endtask

    task automatic test_freeze_branch_reset();
        do_reset();
        fetch_word(32'h3000_0000);
        fetch_word(32'h3000_0004);
        freeze = 1; br_taken = 1; br_offset = 32'd16;
        tick();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL fbr_pc_held: got %h want 00000008", imem_addr); end
        checks++; if (if_instr !== 32'h3000_0004) begin errors++; $display("FAIL fbr_instr_held: got %h want 30000004", if_instr); end
        br_taken = 0;
        fetch_word(32'hBBBB_0002);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fbr_in_buf: got %b want 0", imem_req); end
`ifdef FETCH_STATS_EN
        checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL fbr_flush_count: got %0d want 0", flush_count); end
`endif
        rst = 1; freeze = 0; imem_ack = 1; imem_rdata = 32'hCCCC_0003;
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fbr_rst_pc: got %h want 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fbr_rst_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fbr_rst_req: got %b want 0", imem_req); end
        rst = 0; imem_ack = 0;
        tick();
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL fbr_skid_dropped: got %h want 00000000", if_instr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fbr_post_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL fbr_post_addr: got %h want 00000000", imem_addr); end
`ifdef FETCH_STATS_EN
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL fbr_stall_cycles: got %0d want 1", stall_cycles); end
`endif
    endtask

    task automatic test_wrap();
        w_ack = 0; w_rdata = '0;
        w_rst = 1;
        tick();
        w_rst = 0;
        #1;
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc: got %h want fffffffc", w_addr); end
        w_ack = 1; w_rdata = 32'h6666_0001;
        tick();
        w_ack = 0;
        checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", w_addr); end
        checks++; if (w_if_pc !== 32'h0) begin errors++; $display("FAIL wrap_if_pc: got %h want 00000000", w_if_pc); end
        checks++; if (w_if_instr !== 32'h6666_0001) begin errors++; $display("FAIL wrap_instr: got %h want 66660001", w_if_instr); end
    endtask

    initial begin
        w_rst = 1; w_ack = 0; w_rdata = '0;
        rst = 1; freeze = 0; br_taken = 0; br_offset = '0; imem_ack = 0; imem_rdata = '0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_freeze();
        test_branch();
        test_freeze_branch_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 freeze  input  1  hazard stall from the decode stage; holds the PC and the IF/ID outputs.
REQ-005 br_taken  input  1  branch-taken decision from the decode stage for the instruction held in if_instr.
REQ-006 br_offset  input  32  signed word offset of the branch in decode (sign-extended immediate).
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch byte address; always equals the PC register.
REQ-009 imem_ack  input  1  one-cycle response strobe; imem_rdata is valid for the imem_addr of that same cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 if_instr  output  32  IF/ID instruction register.
REQ-012 if_pc  output  32  IF/ID register holding the fetch address + 4 of if_instr.
REQ-013 if_valid  output  1  if_instr holds a real fetched instruction.

Function
REQ-014 States: FETCH (imem_req=1) and BUF (imem_req=0, one fetched word parked in a skid register).
REQ-015 FETCH, imem_ack=1, freeze=0, br_taken=0: if_instr<=imem_rdata, if_pc<=PC+4, if_valid<=1, PC<=PC+4; stay in FETCH.
REQ-016 FETCH, imem_ack=1, freeze=1: skid<=imem_rdata, skid_pc<=PC+4, PC<=PC+4; IF/ID outputs held; go to BUF.
REQ-017 FETCH, imem_ack=0: PC and IF/ID outputs held (wait state); imem_req stays 1 with a stable address.
REQ-018 BUF, freeze=1: everything held.
REQ-019 BUF, freeze=0, br_taken=0: if_instr<=skid, if_pc<=skid_pc, if_valid<=1; go to FETCH.
REQ-020 br_taken is honoured only when freeze=0 and if_valid=1, and is ignored otherwise.
REQ-021 An honoured branch sets PC<=if_pc + (br_offset<<2), if_instr<=32'h0 (NOP), and if_valid<=0.
REQ-022 An honoured branch also discards any same-cycle imem_ack data and any skid contents, and forces state FETCH.
REQ-023 Branch latency: the target address appears on imem_addr in the cycle after br_taken is sampled.
REQ-024 Exactly one wrong-path slot (the NOP) is inserted per taken branch.
REQ-025 All PC arithmetic is modulo 2^32, so PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without a flag.
REQ-026 Every imem_ack is used exactly once, never duplicated or lost, except when it is dropped by a branch.

Reset
REQ-027 rst has priority over every other input.
REQ-028 During and after reset: PC=RESET_PC, state=FETCH, if_instr=32'h0, if_pc=32'h0, if_valid=0, skid cleared.
REQ-029 imem_req is 0 in any cycle where rst=1, and is 1 from the first cycle after rst deasserts.
REQ-030 A reset mid-wait or in BUF abandons the outstanding fetch; an imem_ack in a reset cycle is ignored.

Configuration
REQ-031 With macro FETCH_STATS_EN defined, the block adds stall_cycles (output, 32) and flush_count (output, 16).
REQ-032 stall_cycles increments in each cycle where imem_req=1 and imem_ack=0.
REQ-033 flush_count increments on each honoured branch.
REQ-034 Both counters saturate at all-ones and reset to 0.
REQ-035 Without FETCH_STATS_EN, these ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-036 Shared package fetch_pkg holds: fetch_state_t (FETCH, BUF), NOP_INSTR=32'h0, PC_STEP=4, and WORD_LEN-based widths.
REQ-037 Counter logic lives in the sub-module fetch_stats, which is instantiated only under FETCH_STATS_EN.

Verification
REQ-038 Zero-wait sequential fetch: RESET_PC=0, imem_ack=1 every cycle.
  -> imem_addr goes 0, 4, 8, 12; if_pc goes 4, 8, 12 one cycle behind; if_valid=1 from the second cycle.
REQ-039 Wait states: imem_ack=1 only every third cycle.
  -> imem_addr holds for 3 cycles per word; if_instr updates only on ack; stall_cycles increments by 2 per word.
REQ-040 Freeze with ack: freeze=1 in the ack cycle of word 0xAAAA_0001 at address 8.
  -> state=BUF, imem_req=0, if_instr unchanged; after freeze drops, if_instr=0xAAAA_0001 and if_pc=12.
REQ-041 Branch with simultaneous ack: if_pc=0x20, br_offset=-2, br_taken=1, imem_ack=1.
  -> next cycle imem_addr=0x18, if_instr=0, if_valid=0; the acked word is never seen; flush_count=1.
REQ-042 Branch while frozen, then reset: br_taken=1 with freeze=1.
  -> PC unchanged.
  Follow-on: rst=1 asserted in BUF.
  -> next cycle PC=RESET_PC, if_valid=0, imem_req=0 during rst, skid word never emitted.
REQ-043 Wrap-around: RESET_PC=32'hFFFF_FFFC with one ack.
  -> imem_addr=0, if_pc=0.
